// File: rtl/data_mem_resp.sv
// Request/response data memory with a fixed access latency, byte/half/word
// access sizes, load sign/zero extension and misalignment/range error reporting.
module data_mem_resp #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [1:0] SZ_B   = 2'b00;
  localparam logic [1:0] SZ_H   = 2'b01;
  localparam logic [1:0] SZ_W   = 2'b10;
  localparam logic [1:0] SZ_BAD = 2'b11;

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

  state_t          state, state_next;
  logic [3:0]      cnt, cnt_next;
  logic            capture;
  logic            rsp_valid_next, rsp_err_next;
  logic [31:0]     rsp_rdata_next;

  logic            we_q, unsigned_q;
  logic [AW+1:0]   addr_q;
  logic [31:0]     wdata_q;
  logic [1:0]      size_q;

  logic [31:0]     mem [DEPTH_WORDS];

  logic            req_bad;
  logic [AW-1:0]   idx;
  logic [1:0]      lane;
  logic [31:0]     rd_word, rd_shift, load_data, wmask, wval;

  // Error classification is done on the live request so the accept edge can branch.
  always_comb begin
    req_bad = (req_size == SZ_BAD)
            | ((req_size == SZ_H) & req_addr[0])
            | ((req_size == SZ_W) & (req_addr[1:0] != 2'b00))
            | (req_addr[31:AW+2] != '0);
  end

  assign idx      = addr_q[AW+1:2];
  assign lane     = addr_q[1:0];
  assign rd_word  = mem[idx];
  assign rd_shift = rd_word >> {lane, 3'b000};

  // Load alignment and extension.
  always_comb begin
    case (size_q)
      SZ_B:    load_data = unsigned_q ? {24'b0, rd_shift[7:0]}
                                      : {{24{rd_shift[7]}}, rd_shift[7:0]};
      SZ_H:    load_data = unsigned_q ? {16'b0, rd_shift[15:0]}
                                      : {{16{rd_shift[15]}}, rd_shift[15:0]};
      default: load_data = rd_word;
    endcase
  end

  // Store lane mask and replicated write data.
  always_comb begin
    case (size_q)
      SZ_B: begin
        wmask = 32'h0000_00FF << {lane, 3'b000};
        wval  = {4{wdata_q[7:0]}};
      end
      SZ_H: begin
        wmask = addr_q[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
        wval  = {2{wdata_q[15:0]}};
      end
      default: begin
        wmask = 32'hFFFF_FFFF;
        wval  = wdata_q;
      end
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    capture        = 1'b0;
    rsp_valid_next = rsp_valid;
    rsp_rdata_next = rsp_rdata;
    rsp_err_next   = rsp_err;
    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          capture = 1'b1;
          if (req_bad) begin
            state_next     = RESP;
            rsp_valid_next = 1'b1;
            rsp_err_next   = 1'b1;
            rsp_rdata_next = '0;
          end else if (WAIT_CYCLES == 0) begin
            state_next = ACCESS;
          end else begin
            state_next = WAIT;
            cnt_next   = 4'(WAIT_CYCLES);
          end
        end
      end
      WAIT: begin
        if (cnt != 4'd0) cnt_next = cnt - 4'd1;
        if (cnt <= 4'd1) state_next = ACCESS;
      end
      ACCESS: begin
        state_next     = RESP;
        rsp_valid_next = 1'b1;
        rsp_err_next   = 1'b0;
        rsp_rdata_next = we_q ? 32'b0 : load_data;
      end
      RESP: begin
        if (rsp_ready) begin
          state_next     = IDLE;
          rsp_valid_next = 1'b0;
          rsp_rdata_next = '0;
          rsp_err_next   = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Control, request capture and response registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      we_q       <= 1'b0;
      unsigned_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= SZ_W;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      req_ready <= (state_next == IDLE);
      rsp_valid <= rsp_valid_next;
      rsp_rdata <= rsp_rdata_next;
      rsp_err   <= rsp_err_next;
      if (capture) begin
        we_q       <= req_we;
        unsigned_q <= req_unsigned;
        addr_q     <= req_addr[AW+1:0];
        wdata_q    <= req_wdata;
        size_q     <= req_size;
      end
    end
  end

  // Storage is not reset; a store commits only on a non-reset ACCESS edge.
  always_ff @(posedge clk) begin
    if (rst && (state == ACCESS) && we_q) begin
      mem[idx] <= (rd_word & ~wmask) | (wval & wmask);
    end
  end

endmodule

// File: tb/tb_data_mem_resp.sv
// Bench for data_mem_resp: one instance with WAIT_CYCLES=2, one with WAIT_CYCLES=0.
module tb_data_mem_resp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst          [2];
  logic        req_valid    [2];
  logic        req_ready    [2];
  logic        req_we       [2];
  logic [31:0] req_addr     [2];
  logic [31:0] req_wdata    [2];
  logic [1:0]  req_size     [2];
  logic        req_unsigned [2];
  logic        rsp_valid    [2];
  logic        rsp_ready    [2];
  logic [31:0] rsp_rdata    [2];
  logic        rsp_err      [2];

  data_mem_resp #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .req_size(req_size[0]), .req_unsigned(req_unsigned[0]), .rsp_valid(rsp_valid[0]),
    .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  data_mem_resp #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .req_size(req_size[1]), .req_unsigned(req_unsigned[1]), .rsp_valid(rsp_valid[1]),
    .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  localparam int NV = 26;
  vec_t vecs [NV];
  exp_t sb [$];
  int   errors = 0;
  int   checks = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input int u, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] size, input logic uns);
    int n;
    n = 0;
    while (req_ready[u] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (req_ready[u] !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL req_ready_timeout: got %b want 1", req_ready[u]);
    end
    req_we[u]       = we;
    req_addr[u]     = addr;
    req_wdata[u]    = wdata;
    req_size[u]     = size;
    req_unsigned[u] = uns;
    req_valid[u]    = 1'b1;
    @(posedge clk);
    #1;
    req_valid[u] = 1'b0;
  endtask

  task automatic issue(input int u, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                       input logic [31:0] exp_rdata, input logic exp_err, input int lat);
    exp_t e;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.lat   = lat;
    sb.push_back(e);
    drive(u, we, addr, wdata, size, uns);
  endtask

  // Waits for the response, compares it against the scoreboard, optionally holds
  // backpressure for `hold` cycles while offering a spurious store, then handshakes.
  task automatic wait_rsp(input int u, input int hold);
    exp_t e;
    int   lat;
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (rsp_valid[u] === 1'b1) break;
    end
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty: got 0 entries want 1");
      return;
    end
    e = sb.pop_front();
    check32("rsp_latency", 32'(lat), 32'(e.lat));
    check32("rsp_rdata", rsp_rdata[u], e.rdata);
    check32("rsp_err", {31'b0, rsp_err[u]}, {31'b0, e.err});
    for (int i = 0; i < hold; i++) begin
      req_we[u]    = 1'b1;
      req_addr[u]  = 32'h10;
      req_wdata[u] = 32'h0BAD_BAD0;
      req_size[u]  = 2'b10;
      req_valid[u] = 1'b1;
      @(negedge clk);
      check32("hold_valid", {31'b0, rsp_valid[u]}, 32'd1);
      check32("hold_rdata", rsp_rdata[u], e.rdata);
      check32("hold_err", {31'b0, rsp_err[u]}, {31'b0, e.err});
      check32("hold_req_ready", {31'b0, req_ready[u]}, 32'd0);
    end
    req_valid[u] = 1'b0;
    rsp_ready[u] = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready[u] = 1'b0;
    check32("post_rsp_idle", {30'b0, req_ready[u], rsp_valid[u]}, 32'b10);
  endtask

  task automatic txn(input int u, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                     input logic [31:0] exp_rdata, input logic exp_err, input int lat);
    issue(u, we, addr, wdata, size, uns, exp_rdata, exp_err, lat);
    wait_rsp(u, 0);
  endtask

  task automatic check_reset_outs(input int u, input string name);
    check32(name, {29'b0, req_ready[u], rsp_valid[u], rsp_err[u]}, 32'b100);
    check32({name, "_rdata"}, rsp_rdata[u], 32'h0);
  endtask

  initial begin
    logic stray;
    int   n;

    vecs[0]  = '{1'b1, 32'h10,  32'hDEAD_BEEF, 2'b10, 1'b0, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b0, 32'h10,  32'h0,         2'b10, 1'b0, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h20,  32'h80FF_7F01, 2'b10, 1'b0, 32'h0000_0000, 1'b0};
    vecs[3]  = '{1'b0, 32'h23,  32'h0,         2'b00, 1'b0, 32'hFFFF_FF80, 1'b0};
    vecs[4]  = '{1'b0, 32'h21,  32'h0,         2'b00, 1'b1, 32'h0000_007F, 1'b0};
    vecs[5]  = '{1'b0, 32'h22,  32'h0,         2'b01, 1'b0, 32'hFFFF_80FF, 1'b0};
    vecs[6]  = '{1'b1, 32'h20,  32'h1234_56AA, 2'b00, 1'b0, 32'h0000_0000, 1'b0};
    vecs[7]  = '{1'b0, 32'h20,  32'h0,         2'b10, 1'b0, 32'h80FF_7FAA, 1'b0};
    vecs[8]  = '{1'b1, 32'hFC,  32'hCAFE_F00D, 2'b10, 1'b0, 32'h0000_0000, 1'b0};
    vecs[9]  = '{1'b1, 32'h00,  32'h0F0F_0F0F, 2'b10, 1'b0, 32'h0000_0000, 1'b0};
    vecs[10] = '{1'b0, 32'h22,  32'h0,         2'b10, 1'b0, 32'h0000_0000, 1'b1};
    vecs[11] = '{1'b0, 32'h01,  32'h0,         2'b01, 1'b0, 32'h0000_0000, 1'b1};
    vecs[12] = '{1'b0, 32'h00,  32'h0,         2'b11, 1'b0, 32'h0000_0000, 1'b1};
    vecs[13] = '{1'b1, 32'h100, 32'h1111_1111, 2'b10, 1'b0, 32'h0000_0000, 1'b1};
    vecs[14] = '{1'b0, 32'hFC,  32'h0,         2'b10, 1'b0, 32'hCAFE_F00D, 1'b0};
    vecs[15] = '{1'b0, 32'h00,  32'h0,         2'b10, 1'b0, 32'h0F0F_0F0F, 1'b0};
    vecs[16] = '{1'b1, 32'h12,  32'h9999_5555, 2'b01, 1'b0, 32'h0000_0000, 1'b0};
    vecs[17] = '{1'b0, 32'h10,  32'h0,         2'b10, 1'b0, 32'h5555_BEEF, 1'b0};
    vecs[18] = '{1'b0, 32'h12,  32'h0,         2'b01, 1'b1, 32'h0000_5555, 1'b0};
    vecs[19] = '{1'b0, 32'h10,  32'h0,         2'b01, 1'b0, 32'hFFFF_BEEF, 1'b0};
    vecs[20] = '{1'b0, 32'h11,  32'h0,         2'b00, 1'b0, 32'hFFFF_FFBE, 1'b0};
    vecs[21] = '{1'b1, 32'h13,  32'h0000_00C3, 2'b00, 1'b0, 32'h0000_0000, 1'b0};
    vecs[22] = '{1'b0, 32'h10,  32'h0,         2'b10, 1'b0, 32'hC355_BEEF, 1'b0};
    vecs[23] = '{1'b0, 32'h13,  32'h0,         2'b00, 1'b1, 32'h0000_00C3, 1'b0};
    vecs[24] = '{1'b1, 32'h13,  32'hFFFF_FFFF, 2'b01, 1'b0, 32'h0000_0000, 1'b1};
    vecs[25] = '{1'b0, 32'h10,  32'h0,         2'b10, 1'b0, 32'hC355_BEEF, 1'b0};

    for (int u = 0; u < 2; u++) begin
      rst[u]          = 1'b0;
      req_valid[u]    = 1'b1;
      req_we[u]       = 1'b0;
      req_addr[u]     = 32'h0;
      req_wdata[u]    = 32'h0;
      req_size[u]     = 2'b10;
      req_unsigned[u] = 1'b0;
      rsp_ready[u]    = 1'b0;
    end

    // A request held during reset must not be taken.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outs(0, "reset_w2");
    check_reset_outs(1, "reset_w0");
    req_valid[0] = 1'b0;
    req_valid[1] = 1'b0;
    rst[0] = 1'b1;
    rst[1] = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outs(0, "after_reset_w2");

    for (int i = 0; i < NV; i++) begin
      txn(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].size, vecs[i].uns,
          vecs[i].rdata, vecs[i].err, vecs[i].err ? 1 : 4);
    end

    // Backpressure with a spurious store offered during RESP.
    issue(0, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'hC355_BEEF, 1'b0, 4);
    wait_rsp(0, 5);
    txn(0, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'hC355_BEEF, 1'b0, 4);

    // Reset while a store sits in WAIT.
    txn(0, 1'b1, 32'h30, 32'hA5A5_A5A5, 2'b10, 1'b0, 32'h0, 1'b0, 4);
    drive(0, 1'b1, 32'h30, 32'h1234_5678, 2'b10, 1'b0);
    check32("busy_in_wait", {31'b0, req_ready[0]}, 32'd0);
    @(negedge clk);
    rst[0] = 1'b0;
    @(posedge clk);
    #1;
    rst[0] = 1'b1;
    check_reset_outs(0, "midop_reset");
    stray = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid[0] !== 1'b0) stray = 1'b1;
    end
    check32("no_stray_rsp", {31'b0, stray}, 32'd0);
    txn(0, 1'b0, 32'h30, 32'h0, 2'b10, 1'b0, 32'hA5A5_A5A5, 1'b0, 4);

    // Zero-wait instance.
    txn(1, 1'b1, 32'h40, 32'h1357_9BDF, 2'b10, 1'b0, 32'h0, 1'b0, 2);
    txn(1, 1'b0, 32'h40, 32'h0, 2'b10, 1'b0, 32'h1357_9BDF, 1'b0, 2);
    txn(1, 1'b0, 32'h41, 32'h0, 2'b00, 1'b0, 32'hFFFF_FF9B, 1'b0, 2);
    txn(1, 1'b0, 32'h42, 32'h0, 2'b01, 1'b1, 32'h0000_1357, 1'b0, 2);
    txn(1, 1'b0, 32'h41, 32'h0, 2'b10, 1'b0, 32'h0, 1'b1, 1);

    // Reset discards a pending response.
    drive(1, 1'b0, 32'h40, 32'h0, 2'b10, 1'b0);
    n = 0;
    while (rsp_valid[1] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check32("pending_rsp_seen", {31'b0, rsp_valid[1]}, 32'd1);
    rst[1] = 1'b0;
    @(posedge clk);
    #1;
    rst[1] = 1'b1;
    check_reset_outs(1, "resp_reset");
    txn(1, 1'b0, 32'h40, 32'h0, 2'b10, 1'b0, 32'h1357_9BDF, 1'b0, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
